// File: rtl/ntt_seq_ctrl.sv
// ntt_seq_ctrl: NTT stage/address sequencer for two BFUs; define SCALE_PASS_EN to append the inverse N^-1 scale pass
module ntt_seq_ctrl #(
  parameter int N    = 256,
  parameter int LOGN = 8,
  parameter int AW   = 8,
  parameter int PIPE = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic [2:0]                  set_state,
  input  logic                        stall,
  output logic                        issue_vld,
  output logic [AW-1:0]               addr0_a,
  output logic [AW-1:0]               addr0_b,
  output logic [AW-1:0]               addr1_a,
  output logic [AW-1:0]               addr1_b,
  output logic [AW-1:0]               tw_addr,
  output logic [1:0]                  bf_mode,
  output logic [$clog2(LOGN+1)-1:0]   stage,
  output logic                        busy,
  output logic                        done
);
  localparam int SW = $clog2(LOGN+1);
  localparam int DW = $clog2(PIPE+1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [AW-2:0] c, c_n;
  logic [SW-1:0] s, s_n;
  logic [1:0] mode, mode_n, cmd_mode;
  logic [DW-1:0] d, d_n;
  logic start_d, st_edge, cmd_ok, iss, bfly;
  logic [AW-1:0] j0, j1, pa0, pa1, hf;
  logic [SW-1:0] sh;
  function automatic logic [AW-1:0] pa(input logic [AW-1:0] j, input logic [SW-1:0] k);
    return ((j >> k) << (k + 1'b1)) | (j & ((AW'(1) << k) - AW'(1)));
  endfunction
  assign st_edge  = start & ~start_d;
  assign cmd_ok   = set_state == 3'b001 || set_state == 3'b011 || set_state == 3'b010;
  assign cmd_mode = set_state == 3'b001 ? 2'd0 : set_state == 3'b011 ? 2'd1 : 2'd2;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      c       <= '0;
      s       <= '0;
      mode    <= '0;
      d       <= '0;
      start_d <= 1'b0;
    end else begin
      state   <= state_n;
      c       <= c_n;
      s       <= s_n;
      mode    <= mode_n;
      d       <= d_n;
      start_d <= start;
    end
  end
  always_comb begin
    state_n = state;
    c_n     = c;
    s_n     = s;
    mode_n  = mode;
    d_n     = d;
    case (state)
      IDLE: if (st_edge && cmd_ok) begin
        state_n = ISSUE;
        mode_n  = cmd_mode;
        c_n     = '0;
        s_n     = '0;
      end
      ISSUE: if (!stall) begin
        c_n = c + 1'b1;
        if (c == (mode[1] ? (AW-1)'(N/2-1) : (AW-1)'(N/4-1))) begin
          state_n = DRAIN;
          c_n     = '0;
          d_n     = '0;
        end
      end
      DRAIN: begin
        d_n = d + 1'b1;
        if (d == DW'(PIPE-1)) begin
          d_n = '0;
          if (!mode[1] && s != SW'(LOGN-1)) begin
            state_n = ISSUE;
            s_n     = s + 1'b1;
          end
`ifdef SCALE_PASS_EN
          else if (mode == 2'd1) begin
            state_n = ISSUE;
            mode_n  = 2'd3;
            s_n     = SW'(LOGN);
          end
`endif
          else state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // forward halves shrink from N/2, inverse halves grow from 1; sh is log2(half)
  assign bfly = ~mode[1];
  assign sh   = mode == 2'd0 ? SW'(LOGN-1) - s : s;
  assign j0   = {c, 1'b0};
  assign j1   = {c, 1'b1};
  assign hf   = AW'(1) << sh;
  assign pa0  = pa(j0, sh);
  assign pa1  = pa(j1, sh);
  assign iss  = state == ISSUE;
  assign issue_vld = iss & ~stall;
  assign busy      = state == ISSUE || state == DRAIN;
  assign done      = state == DONE;
  assign stage     = busy ? s : '0;
  assign bf_mode   = busy ? mode : '0;
  assign addr0_a   = !iss ? '0 : bfly ? pa0 : j0;
  assign addr0_b   = !iss ? '0 : bfly ? pa0 + hf : j0;
  assign addr1_a   = !iss ? '0 : bfly ? pa1 : j1;
  assign addr1_b   = !iss ? '0 : bfly ? pa1 + hf : j1;
  assign tw_addr   = !iss ? '0 : bfly ? (AW'(1) << (SW'(LOGN-1) - sh)) + (j0 >> sh) : mode[0] ? AW'(N-1) : '0;
endmodule
